// File: rtl/result_stream_pkg.sv
// rtl/result_stream_pkg.sv - shared constants, types and lane helpers for the result lane streamer
package result_stream_pkg;

  localparam int LANE_W   = 8;
  localparam int LANES    = 8;
  localparam int RESULT_W = 64;

  typedef logic [2:0] lane_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } stream_state_t;

  // Negative lanes clamp to zero; positive lanes pass through untouched.
  function automatic logic [LANE_W-1:0] relu8(input logic [LANE_W-1:0] lane);
    return lane[LANE_W-1] ? '0 : lane;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy level
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/result_lane_streamer.sv
// rtl/result_lane_streamer.sv - captures datapath results on done edges and streams them as 8-bit lanes
module result_lane_streamer
  import result_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit RELU_EN    = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                done_i,
  input  logic [RESULT_W-1:0] result_i,
  output logic [LANE_W-1:0]   m_data_o,
  output logic [2:0]          m_lane_o,
  output logic                m_last_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic                done_q;
  lane_idx_t           lane_q;
  logic                overflow_q;
  stream_state_t       state_q;
  stream_state_t       state_d;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AW:0]         fifo_level;
  logic [RESULT_W-1:0] head;
  logic [LANE_W-1:0]   lane_raw;
  logic                capture;
  logic                beat;
  logic                pop;
  logic                push;

  assign capture = done_i & ~done_q;
  assign beat    = ~fifo_empty & m_ready_i;
  assign pop     = beat & (lane_q == 3'd7);
  assign push    = capture & (~fifo_full | pop);

  sync_fifo #(
    .WIDTH (RESULT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (result_i),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .head_o  (head)
  );

  // done_q resets high so a done level present at reset release is not an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q     <= 1'b1;
      lane_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      done_q  <= done_i;
      state_q <= state_d;
      if (beat) lane_q <= lane_q + 1'b1;
      if (capture && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (pop && !push && (fifo_level == 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated by occupancy since FIFO storage is not cleared by reset.
  assign lane_raw   = head[{lane_q, 3'b000} +: LANE_W];
  assign m_valid_o  = ~fifo_empty;
  assign m_data_o   = fifo_empty ? '0 : (RELU_EN ? relu8(lane_raw) : lane_raw);
  assign m_lane_o   = lane_q;
  assign m_last_o   = ~fifo_empty & (lane_q == 3'd7);
  assign busy_o     = (state_q == ST_STREAM);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_result_lane_streamer.sv
// tb/tb_result_lane_streamer.sv - directed table-driven bench for result_lane_streamer
module tb_result_lane_streamer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        done_i;
  logic [63:0] result_i;
  logic        m_ready_i;

  logic [7:0]  d0_data, d1_data;
  logic [2:0]  d0_lane, d1_lane;
  logic        d0_last, d1_last, d0_valid, d1_valid;
  logic        d0_busy, d1_busy, d0_ovf, d1_ovf;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];

  typedef struct {
    logic [63:0] word;
    logic [63:0] exp_plain;
    logic [63:0] exp_relu;
  } vec_t;

  vec_t vecs [4];

  always #5 clk_i = ~clk_i;

  result_lane_streamer #(.FIFO_DEPTH(4), .RELU_EN(1'b0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .done_i(done_i), .result_i(result_i),
    .m_data_o(d0_data), .m_lane_o(d0_lane), .m_last_o(d0_last), .m_valid_o(d0_valid),
    .m_ready_i(m_ready_i), .busy_o(d0_busy), .overflow_o(d0_ovf)
  );

  result_lane_streamer #(.FIFO_DEPTH(4), .RELU_EN(1'b1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .done_i(done_i), .result_i(result_i),
    .m_data_o(d1_data), .m_lane_o(d1_lane), .m_last_o(d1_last), .m_valid_o(d1_valid),
    .m_ready_i(m_ready_i), .busy_o(d1_busy), .overflow_o(d1_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] lane_of(input logic [63:0] w, input int k);
    return w[k*8 +: 8];
  endfunction

  function automatic logic [63:0] wgen(input int k);
    return 64'h0706_0504_0302_0100 + 64'h1010_1010_1010_1010 * 64'(k);
  endfunction

  task automatic pulse(input logic [63:0] word);
    result_i = word;
    done_i   = 1'b1;
    step();
    done_i   = 1'b0;
    step();
  endtask

  // Drains with ready high, checking every beat against the expected word queue.
  task automatic drain(input int max_cycles, output int beats);
    int lane;
    beats = 0;
    lane  = 0;
    m_ready_i = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (d0_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(d0_data), 64'hx);
        end else begin
          chk("drain_data", 64'(d0_data), 64'(lane_of(exp_q[0], lane)));
          chk("drain_lane", 64'(d0_lane), 64'(lane));
          chk("drain_last", 64'(d0_last), 64'(lane == 7));
          if (lane == 7) begin
            void'(exp_q.pop_front());
            lane = 0;
          end else begin
            lane++;
          end
        end
        beats++;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int beats;
    int lane;
    int delivered;
    logic was_valid;

    vecs[0] = '{word: 64'h0102_0304_0506_0708, exp_plain: 64'h0102_0304_0506_0708, exp_relu: 64'h0102_0304_0506_0708};
    vecs[1] = '{word: 64'h80FF_7F01_00FE_8101, exp_plain: 64'h80FF_7F01_00FE_8101, exp_relu: 64'h0000_7F01_0000_0001};
    vecs[2] = '{word: 64'hFFFF_FFFF_FFFF_FFFF, exp_plain: 64'hFFFF_FFFF_FFFF_FFFF, exp_relu: 64'h0000_0000_0000_0000};
    vecs[3] = '{word: 64'h7F80_0000_1234_5678, exp_plain: 64'h7F80_0000_1234_5678, exp_relu: 64'h7F00_0000_1234_5678};

    rst_i = 1'b1; done_i = 1'b1; m_ready_i = 1'b0; result_i = 64'hDEAD_BEEF_CAFE_F00D;
    step(); step();
    chk("rst_valid", 64'(d0_valid), 64'd0);
    chk("rst_data", 64'(d0_data), 64'd0);
    chk("rst_lane", 64'(d0_lane), 64'd0);
    chk("rst_last", 64'(d0_last), 64'd0);
    chk("rst_busy", 64'(d0_busy), 64'd0);
    chk("rst_ovf", 64'(d0_ovf), 64'd0);
    chk("rst_relu_data", 64'(d1_data), 64'd0);
    rst_i = 1'b0;
    step(); step(); step();
    chk("no_capture_done_high_at_release", 64'(d0_valid), 64'd0);
    done_i = 1'b0;
    step();

    m_ready_i = 1'b1;
    for (int v = 0; v < 4; v++) begin
      result_i = vecs[v].word;
      done_i   = 1'b1;
      step();
      chk("latency_valid", 64'(d0_valid), 64'd1);
      chk("busy_high", 64'(d0_busy), 64'd1);
      done_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
        chk("vec_valid", 64'(d0_valid), 64'd1);
        chk("vec_lane", 64'(d0_lane), 64'(k));
        chk("vec_last", 64'(d0_last), 64'(k == 7));
        chk("vec_data", 64'(d0_data), 64'(lane_of(vecs[v].exp_plain, k)));
        chk("vec_relu_data", 64'(d1_data), 64'(lane_of(vecs[v].exp_relu, k)));
        step();
      end
      chk("vec_end_valid", 64'(d0_valid), 64'd0);
      chk("vec_end_busy", 64'(d0_busy), 64'd0);
    end

    // Back-pressure with pseudo-random ready.
    m_ready_i = 1'b0;
    pulse(64'hA1B2_C3D4_E5F6_0718);
    pulse(64'h1122_3344_5566_7788);
    exp_q = {64'hA1B2_C3D4_E5F6_0718, 64'h1122_3344_5566_7788};
    lane = 0;
    delivered = 0;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      was_valid = d0_valid;
      if (was_valid) begin
        chk("bp_data", 64'(d0_data), 64'(lane_of(exp_q[0], lane)));
        chk("bp_lane", 64'(d0_lane), 64'(lane));
        chk("bp_last", 64'(d0_last), 64'(lane == 7));
      end
      m_ready_i = 1'($urandom_range(0, 1));
      step();
      if (was_valid && m_ready_i) begin
        delivered++;
        if (lane == 7) begin
          void'(exp_q.pop_front());
          lane = 0;
        end else begin
          lane++;
        end
      end
    end
    chk("bp_delivered", 64'(delivered), 64'd16);
    step();
    chk("bp_end_valid", 64'(d0_valid), 64'd0);

    // Overflow: five captures into a depth-4 FIFO with ready low.
    m_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse(wgen(k));
      if (k == 3) chk("ovf_before", 64'(d0_ovf), 64'd0);
      if (k == 4) chk("ovf_set", 64'(d0_ovf), 64'd1);
    end
    exp_q = {wgen(0), wgen(1), wgen(2), wgen(3)};
    drain(40, beats);
    chk("ovf_beats", 64'(beats), 64'd32);
    chk("ovf_sticky", 64'(d0_ovf), 64'd1);
    chk("ovf_queue_empty", 64'(exp_q.size()), 64'd0);

    // Capture on the same edge as a lane-7 pop while full.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    chk("ovf_cleared", 64'(d0_ovf), 64'd0);
    m_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) pulse(wgen(k));
    m_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("edge_lane7", 64'(d0_lane), 64'd7);
    result_i = wgen(4);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("edge_no_ovf", 64'(d0_ovf), 64'd0);
    exp_q = {wgen(1), wgen(2), wgen(3), wgen(4)};
    drain(40, beats);
    chk("edge_beats", 64'(beats), 64'd32);
    chk("edge_no_ovf_end", 64'(d0_ovf), 64'd0);

    // done_i held high for 10 cycles yields one word.
    m_ready_i = 1'b0;
    result_i = 64'h0F1E_2D3C_4B5A_6978;
    done_i = 1'b1;
    for (int k = 0; k < 10; k++) step();
    done_i = 1'b0;
    exp_q = {64'h0F1E_2D3C_4B5A_6978};
    drain(30, beats);
    chk("hold_beats", 64'(beats), 64'd8);

    // Reset in the middle of a word with a second word buffered.
    m_ready_i = 1'b0;
    pulse(wgen(5));
    pulse(wgen(6));
    m_ready_i = 1'b1;
    step(); step(); step();
    chk("mid_lane3", 64'(d0_lane), 64'd3);
    done_i = 1'b1;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(d0_valid), 64'd0);
    chk("mid_rst_data", 64'(d0_data), 64'd0);
    chk("mid_rst_lane", 64'(d0_lane), 64'd0);
    chk("mid_rst_last", 64'(d0_last), 64'd0);
    chk("mid_rst_busy", 64'(d0_busy), 64'd0);
    step(); step();
    rst_i = 1'b0;
    step(); step(); step();
    chk("mid_no_capture", 64'(d0_valid), 64'd0);
    done_i = 1'b0;
    step();
    chk("mid_still_idle", 64'(d0_valid), 64'd0);
    result_i = 64'h0102_0304_0506_0708;
    done_i = 1'b1;
    step();
    chk("mid_recapture_valid", 64'(d0_valid), 64'd1);
    done_i = 1'b0;
    exp_q = {64'h0102_0304_0506_0708};
    drain(20, beats);
    chk("mid_beats", 64'(beats), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
